// File: rtl/uart_rx_os16_pkg.sv
// Shared constants for the 16x-oversampling UART receiver: state encoding,
// frame width and the mid-bit sample tick.
package uart_rx_os16_pkg;

    localparam int RX_DATA_BITS = 8;
    localparam int RX_SAMPLE_PT = 7;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_os16_if.sv
// Host-side byte interface of the UART receiver. The receiver drives it
// (master), the host consumes it (slave). parity_err exists only with UART_RX_PARITY_EN.
interface uart_rx_os16_if #(
    parameter int DATA_BITS = uart_rx_os16_pkg::RX_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 new_rx_data;
    logic                 frame_err;
    logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output rx_data, new_rx_data, frame_err, rx_busy, parity_err);
    modport slave  (input  rx_data, new_rx_data, frame_err, rx_busy, parity_err);
`else
    modport master (output rx_data, new_rx_data, frame_err, rx_busy);
    modport slave  (input  rx_data, new_rx_data, frame_err, rx_busy);
`endif
endinterface

// File: rtl/uart_rx_os16_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line does not look like an edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), timed by a 16x
// baud clock enable. Samples mid-bit, assembles LSB-first, strobes the byte out.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int DATA_BITS = RX_DATA_BITS,
    parameter int SAMPLE_PT = RX_SAMPLE_PT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ce_16,
    input  logic            ser_in,
    uart_rx_os16_if.master  rx_if
);
    localparam logic [3:0] SAMPLE_TICK = 4'(SAMPLE_PT);
    localparam logic [3:0] LAST_TICK   = 4'd15;
    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

    logic ser_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (ser_in),
        .q     (ser_s)
    );

    rx_state_e            state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ser_s_d_q, ser_s_d_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 new_rx_data_q, new_rx_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_busy_q, rx_busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        ser_s_d_d     = ser_s_d_q;
        rx_data_d     = rx_data_q;
        new_rx_data_d = 1'b0;
        frame_err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d     = par_bit_q;
        parity_err_d  = 1'b0;
`endif
        if (ce_16) begin
            ser_s_d_d  = ser_s;
            tick_cnt_d = tick_cnt_q + 4'd1;
            case (state_q)
                RX_IDLE: begin
                    tick_cnt_d = '0;
                    // Edge needs a high sample first, so a stuck-low line yields one frame only.
                    if (!ser_s && ser_s_d_q) state_d = RX_START;
                end
                RX_START: begin
                    if (tick_cnt_q == SAMPLE_TICK) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ser_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    // tick_cnt restarted at the start-bit sample, so 15 lands one bit later.
                    if (tick_cnt_q == LAST_TICK) begin
                        shift_d   = {ser_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = RX_PARITY;
`else
                            state_d = RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        par_bit_d = ser_s;
                        state_d   = RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        rx_data_d     = shift_q;
                        new_rx_data_d = 1'b1;
                        frame_err_d   = ~ser_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_d  = (^shift_q) ^ par_bit_q;
`endif
                        state_d       = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
        rx_busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RX_IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            ser_s_d_q     <= 1'b1;
            rx_data_q     <= '0;
            new_rx_data_q <= 1'b0;
            frame_err_q   <= 1'b0;
            rx_busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            ser_s_d_q     <= ser_s_d_d;
            rx_data_q     <= rx_data_d;
            new_rx_data_q <= new_rx_data_d;
            frame_err_q   <= frame_err_d;
            rx_busy_q     <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= par_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.new_rx_data = new_rx_data_q;
    assign rx_if.frame_err   = frame_err_q;
    assign rx_if.rx_busy     = rx_busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err  = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: table of frames, hand-written corner
// sequences, then random frames checked against a queue of sent frames.
module tb_uart_rx_os16;
    logic clock = 1'b0;
    logic reset;
    logic ce_16;
    logic ser_in;

    uart_rx_os16_if rx_if ();

    uart_rx_os16 dut (
        .clock  (clock),
        .reset  (reset),
        .ce_16  (ce_16),
        .ser_in (ser_in),
        .rx_if  (rx_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        int         stop_ticks;
        int         gap;
        int         ce_per;
        logic       exp_ferr;
    } vec_t;

    frame_t exp_q[$];
    frame_t rcv_q[$];
    int     errors = 0;
    int     checks = 0;
    int     strobe_cnt = 0;
    int     ce_per = 4;
    logic   prev_new = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture every strobe; a strobe may never last more than one clock.
    always @(negedge clock) begin
        if (!reset && rx_if.new_rx_data === 1'b1) begin
            frame_t f;
            check("strobe_width", {31'd0, prev_new}, 32'd0);
            f.data = rx_if.rx_data;
            f.ferr = rx_if.frame_err;
`ifdef UART_RX_PARITY_EN
            f.perr = rx_if.parity_err;
`else
            f.perr = 1'b0;
`endif
            rcv_q.push_back(f);
            strobe_cnt++;
        end
        prev_new = rx_if.new_rx_data;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        ce_16 = 1'b0;
        repeat (ce_per - 1) begin @(posedge clock); #1; end
        ce_16 = 1'b1;
        @(posedge clock); #1;
        ce_16 = 1'b0;
    endtask

    task automatic send_bit(input logic v, input int n);
        ser_in = v;
        repeat (n) tick();
    endtask

    // Frame driver and model: whatever is sent is what must come out.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic pflip,
                              input int stop_ticks);
        frame_t f;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ pflip, 16);
        f.perr = pflip;
`else
        f.perr = 1'b0;
`endif
        send_bit(stop, stop_ticks);
        f.data = data;
        f.ferr = ~stop;
        exp_q.push_back(f);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, rcv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            check({tag, "_data"}, {24'd0, rcv_q[i].data}, {24'd0, exp_q[i].data});
            check({tag, "_ferr"}, {31'd0, rcv_q[i].ferr}, {31'd0, exp_q[i].ferr});
`ifdef UART_RX_PARITY_EN
            check({tag, "_perr"}, {31'd0, rcv_q[i].perr}, {31'd0, exp_q[i].perr});
`endif
        end
        rcv_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t   vecs[7];
        int     s0;
        logic [7:0] d0;

        // data, stop, pflip, stop_ticks, gap, ce_per, exp_ferr
        vecs[0] = '{8'h55, 1'b1, 1'b0, 16, 4, 4, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b0,  9, 0, 4, 1'b0}; // next start falls right after the stop sample
        vecs[2] = '{8'h0F, 1'b1, 1'b0, 16, 4, 4, 1'b0};
        vecs[3] = '{8'hC6, 1'b1, 1'b0, 16, 6, 1, 1'b0};
        vecs[4] = '{8'h3B, 1'b0, 1'b0, 16, 6, 2, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 16, 6, 3, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 16, 6, 5, 1'b0};

        reset  = 1'b1;
        ce_16  = 1'b0;
        ser_in = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
        check("rst_new", {31'd0, rx_if.new_rx_data}, 32'd0);
        check("rst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        reset = 1'b0;
        send_bit(1'b1, 20);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            ce_per = vecs[i].ce_per;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].pflip, vecs[i].stop_ticks);
            check("vec_exp_ferr", {31'd0, exp_q[exp_q.size()-1].ferr}, {31'd0, vecs[i].exp_ferr});
            if (vecs[i].gap > 0) begin
                send_bit(1'b1, vecs[i].gap);
                check("vec_busy_idle", {31'd0, rx_if.rx_busy}, 32'd0);
            end
        end
        compare("table");

        // Glitch in IDLE: start qualification rejects it
        ce_per = 4;
        s0 = strobe_cnt;
        d0 = rx_if.rx_data;
        send_bit(1'b0, 3);
        check("glitch_busy_start", {31'd0, rx_if.rx_busy}, 32'd1);
        send_bit(1'b1, 20);
        check("glitch_busy_end", {31'd0, rx_if.rx_busy}, 32'd0);
        check("glitch_strobes", strobe_cnt, s0);
        check("glitch_rx_data", {24'd0, rx_if.rx_data}, {24'd0, d0});

        // Break: bad stop bit, line held low 40 bit times
        send_frame(8'h81, 1'b0, 1'b0, 16);
        send_bit(1'b0, 40 * 16);
        check("break_strobes", rcv_q.size(), 1);
        send_bit(1'b1, 20);
        send_frame(8'h5A, 1'b1, 1'b0, 16);
        send_bit(1'b1, 4);
        compare("break");

        // Reset during bit 4 of 0xFF
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
        check("mid_rst_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        check("mid_rst_new", {31'd0, rx_if.new_rx_data}, 32'd0);
        check("mid_rst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        send_bit(1'b1, 20);
        send_frame(8'h3C, 1'b1, 1'b0, 16);
        send_bit(1'b1, 4);
        compare("after_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 16);
        send_bit(1'b1, 4);
        send_frame(8'h07, 1'b1, 1'b1, 16);
        send_bit(1'b1, 4);
        compare("parity");
`endif

        // Random frames, rates and gaps
        for (int i = 0; i < 40; i++) begin
            ce_per = $urandom_range(1, 5);
            send_frame(8'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom), 16);
            send_bit(1'b1, $urandom_range(2, 20));
        end
        compare("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
